// File: rtl/bcd_down_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_down_counter_if
// Description : Load/count/status bundle for the BCD down-counter.
//               master = the block that loads and enables the counter,
//               slave  = the counter itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_down_counter_if #(
  parameter int DIGITS = 2
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  en;
  logic [4*DIGITS-1:0]   cnt;
  logic                  bout;
  logic                  zero;
  logic                  load_err;

  modport master (
    output load, load_val, en,
    input  cnt, bout, zero, load_err
  );

  modport slave (
    input  load, load_val, en,
    output cnt, bout, zero, load_err
  );
endinterface
`default_nettype wire

// File: rtl/bcd_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_down_counter
// Description : Multi-digit BCD down-counter with parallel load (invalid
//               digits clamped to 9), registered borrow-out and optional
//               auto-reload of the last loaded value on wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_down_counter #(
  parameter int DIGITS      = 2,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  wire logic          clk,
  input  wire logic          rstn,
  bcd_down_counter_if.slave  bus
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] c_all_nines = {DIGITS{4'h9}};

  logic [W-1:0]      r_cnt;
  logic [W-1:0]      r_reload;
  logic              r_bout;
  logic              r_load_err;

  logic [W-1:0]      w_clamped;
  logic [DIGITS-1:0] w_digit_err;
  logic [W-1:0]      w_dec;
  logic              w_is_zero;
  logic [W-1:0]      w_cnt_nxt;
  logic [W-1:0]      w_reload_nxt;
  logic              w_bout_nxt;
  logic              w_load_err_nxt;

  // Per-digit validation of the load value: anything above 9 becomes 9.
  for (genvar g = 0; g < DIGITS; g++) begin : g_clamp
    assign w_digit_err[g]     = (bus.load_val[4*g +: 4] > 4'd9);
    assign w_clamped[4*g +: 4] = w_digit_err[g] ? 4'd9 : bus.load_val[4*g +: 4];
  end

  assign w_is_zero = (r_cnt == '0);

  // Ripple-borrow decrement: zeros become 9 and pass the borrow upward.
  always_comb begin
    logic borrow;
    borrow = 1'b1;
    w_dec  = r_cnt;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (r_cnt[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_cnt[4*i +: 4] - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
  end

  // Next-state selection with priority load > en > hold.
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_reload_nxt   = r_reload;
    w_bout_nxt     = 1'b0;
    w_load_err_nxt = 1'b0;
    if (bus.load) begin
      w_cnt_nxt      = w_clamped;
      w_reload_nxt   = w_clamped;
      w_load_err_nxt = |w_digit_err;
    end else if (bus.en) begin
      if (w_is_zero) begin
        w_cnt_nxt  = AUTO_RELOAD ? r_reload : c_all_nines;
        w_bout_nxt = 1'b1;
      end else begin
        w_cnt_nxt  = w_dec;
      end
    end
  end

  // Counter, reload value and one-cycle status pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt      <= '0;
      r_reload   <= '0;
      r_bout     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_reload   <= w_reload_nxt;
      r_bout     <= w_bout_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  assign bus.cnt      = r_cnt;
  assign bus.bout     = r_bout;
  assign bus.load_err = r_load_err;
  assign bus.zero     = w_is_zero;

endmodule
`default_nettype wire

// File: tb/tb_bcd_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_down_counter
// Description : Scoreboard bench for bcd_down_counter. Three instances:
//               0 = 2 digits wrap-to-99, 1 = 2 digits auto-reload,
//               2 = 4 digits wrap-to-9999.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_down_counter;

  logic clk;
  logic rstn;

  bcd_down_counter_if #(.DIGITS(2)) if0 ();
  bcd_down_counter_if #(.DIGITS(2)) if1 ();
  bcd_down_counter_if #(.DIGITS(4)) if2 ();

  bcd_down_counter #(.DIGITS(2), .AUTO_RELOAD(1'b0)) u_d0 (.clk(clk), .rstn(rstn), .bus(if0));
  bcd_down_counter #(.DIGITS(2), .AUTO_RELOAD(1'b1)) u_d1 (.clk(clk), .rstn(rstn), .bus(if1));
  bcd_down_counter #(.DIGITS(4), .AUTO_RELOAD(1'b0)) u_d2 (.clk(clk), .rstn(rstn), .bus(if2));

  typedef struct {
    int          id;
    logic [15:0] cnt;
    logic        bout;
    logic        zero;
    logic        lerr;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    checks_total  = 0;
  int    checks_passed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one instance's outputs against an expected record.
  task automatic compare(input string nm, input exp_t e);
    logic [15:0] c;
    logic        b, z, l;
    case (e.id)
      0:       begin c = {8'h00, if0.cnt}; b = if0.bout; z = if0.zero; l = if0.load_err; end
      1:       begin c = {8'h00, if1.cnt}; b = if1.bout; z = if1.zero; l = if1.load_err; end
      default: begin c = if2.cnt;          b = if2.bout; z = if2.zero; l = if2.load_err; end
    endcase
    checks_total++;
    if (c !== e.cnt || b !== e.bout || z !== e.zero || l !== e.lerr)
      $display("FAIL %s (dut%0d): got cnt=%h bout=%b zero=%b load_err=%b, expected cnt=%h bout=%b zero=%b load_err=%b",
               nm, e.id, c, b, z, l, e.cnt, e.bout, e.zero, e.lerr);
    else
      checks_passed++;
  endtask

  // Monitor: one registered result per clock, popped just after the edge.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n = nq.pop_front();
        compare(n, e);
      end
    end
  end

  task automatic drive(input int id, input logic ld, input logic [15:0] v, input logic e);
    if0.load = 1'b0; if0.en = 1'b0; if0.load_val = '0;
    if1.load = 1'b0; if1.en = 1'b0; if1.load_val = '0;
    if2.load = 1'b0; if2.en = 1'b0; if2.load_val = '0;
    case (id)
      0:       begin if0.load = ld; if0.en = e; if0.load_val = v[7:0]; end
      1:       begin if1.load = ld; if1.en = e; if1.load_val = v[7:0]; end
      default: begin if2.load = ld; if2.en = e; if2.load_val = v;      end
    endcase
  endtask

  // Apply one cycle of stimulus and queue the result expected after the edge.
  task automatic step(input int id, input logic ld, input logic [15:0] v, input logic e,
                      input logic [15:0] ec, input logic eb, input logic el, input string nm);
    exp_t x;
    @(negedge clk);
    drive(id, ld, v, e);
    x.id = id; x.cnt = ec; x.bout = eb; x.zero = (ec == 16'h0); x.lerr = el;
    q.push_back(x);
    nq.push_back(nm);
  endtask

  task automatic idle();
    @(negedge clk);
    drive(0, 1'b0, 16'h0, 1'b0);
  endtask

  function automatic logic [15:0] bcd2(input int v);
    bcd2 = 16'((v / 10) << 4) | 16'(v % 10);
  endfunction

  initial begin
    exp_t r;
    rstn = 1'b0;
    drive(0, 1'b0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);

    // Reset state of all three instances.
    for (int i = 0; i < 3; i++) begin
      r.id = i; r.cnt = 16'h0; r.bout = 1'b0; r.zero = 1'b1; r.lerr = 1'b0;
      compare("reset_state", r);
    end
    rstn = 1'b1;

    // Simultaneous load and en with cnt = 0: load wins, no borrow.
    step(0, 1'b1, 16'h0045, 1'b1, 16'h0045, 1'b0, 1'b0, "load_beats_en");

    // Countdown from 12 through 00 and wrap to 99.
    step(0, 1'b1, 16'h0012, 1'b0, 16'h0012, 1'b0, 1'b0, "load_12");
    for (int i = 11; i >= 0; i--)
      step(0, 1'b0, 16'h0, 1'b1, bcd2(i), 1'b0, 1'b0, "countdown");
    step(0, 1'b0, 16'h0, 1'b1, 16'h0099, 1'b1, 1'b0, "wrap_to_99");
    step(0, 1'b0, 16'h0, 1'b0, 16'h0099, 1'b0, 1'b0, "hold_after_wrap");

    // Invalid BCD digit clamps to 9.
    step(0, 1'b1, 16'h003A, 1'b0, 16'h0039, 1'b0, 1'b1, "clamp_3A");
    step(0, 1'b0, 16'h0, 1'b1, 16'h0038, 1'b0, 1'b0, "load_err_clears");

    // Asynchronous reset between clock edges.
    step(0, 1'b1, 16'h0037, 1'b0, 16'h0037, 1'b0, 1'b0, "load_37");
    idle();
    #2;
    rstn = 1'b0;
    #1;
    r.id = 0; r.cnt = 16'h0; r.bout = 1'b0; r.zero = 1'b1; r.lerr = 1'b0;
    compare("async_reset", r);
    @(negedge clk);
    rstn = 1'b1;

    // Auto-reload: 03 -> 02 -> 01 -> 00 -> 03 (borrow), then hold.
    step(1, 1'b1, 16'h0003, 1'b0, 16'h0003, 1'b0, 1'b0, "ar_load_03");
    step(1, 1'b0, 16'h0, 1'b1, 16'h0002, 1'b0, 1'b0, "ar_dec");
    step(1, 1'b0, 16'h0, 1'b1, 16'h0001, 1'b0, 1'b0, "ar_dec");
    step(1, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b0, 1'b0, "ar_dec_zero");
    step(1, 1'b0, 16'h0, 1'b1, 16'h0003, 1'b1, 1'b0, "ar_reload");
    for (int i = 0; i < 3; i++)
      step(1, 1'b0, 16'h0, 1'b0, 16'h0003, 1'b0, 1'b0, "ar_hold");

    // Auto-reload of a clamped value: 3A -> 39, count down, reload 39.
    step(1, 1'b1, 16'h003A, 1'b0, 16'h0039, 1'b0, 1'b1, "ar_clamp_3A");
    for (int i = 38; i >= 0; i--)
      step(1, 1'b0, 16'h0, 1'b1, bcd2(i), 1'b0, 1'b0, "ar_countdown");
    step(1, 1'b0, 16'h0, 1'b1, 16'h0039, 1'b1, 1'b0, "ar_reload_39");
    step(1, 1'b0, 16'h0, 1'b1, 16'h0038, 1'b0, 1'b0, "ar_bout_clears");

    // Reload value 0: stays at 0, borrow every enabled cycle.
    step(1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "ar_load_00");
    step(1, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b1, 1'b0, "ar_zero_reload");
    step(1, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b1, 1'b0, "ar_zero_reload");
    step(1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b0, "ar_zero_hold");

    // Four-digit borrow chain and wide clamp.
    step(2, 1'b1, 16'h1000, 1'b0, 16'h1000, 1'b0, 1'b0, "d4_load_1000");
    step(2, 1'b0, 16'h0, 1'b1, 16'h0999, 1'b0, 1'b0, "d4_borrow_chain");
    step(2, 1'b1, 16'hF5B0, 1'b0, 16'h9590, 1'b0, 1'b1, "d4_clamp");
    step(2, 1'b0, 16'h0, 1'b1, 16'h9589, 1'b0, 1'b0, "d4_dec");
    step(2, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "d4_load_0");
    step(2, 1'b0, 16'h0, 1'b1, 16'h9999, 1'b1, 1'b0, "d4_wrap");
    idle();

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #3;
    checks_total++;
    if (q.size() != 0)
      $display("FAIL drain: got %0d pending results, expected 0", q.size());
    else
      checks_passed++;

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
`default_nettype wire
